// File: rtl/bmult_18x18.sv
// 18x18 multiplier, one register stage: radix-4 Booth rows, 3:2 CSA tree, final adder.
// Build option: define BMULT_SIGNED_EN for two's-complement operands (default unsigned).
module bmult_18x18 (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] A,
  input  logic [17:0] B,
  output logic [35:0] P
);

  localparam int N  = 18;
  localparam int PW = 2 * N;
  localparam int MW = N + 2;
  localparam int NR = 12;

`ifdef BMULT_SIGNED_EN
  localparam int   ND  = 9;
  localparam logic SGN = 1'b1;
`else
  localparam int   ND  = 10;
  localparam logic SGN = 1'b0;
`endif

  // Each row carries an inverted sign bit (+2^19 bias); this constant removes all biases.
  function automatic logic [PW-1:0] sign_k();
    logic [PW-1:0] k;
    k = '0;
    for (int j = 0; j < ND; j++) k = k - (PW'(1) << (MW - 1 + 2 * j));
    return k;
  endfunction

  localparam logic [PW-1:0] SIGN_K = sign_k();

  function automatic logic [PW-1:0] csa_s(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                          input logic [PW-1:0] c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [PW-1:0] csa_c(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                          input logic [PW-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  logic [MW-1:0] w_a_ext;
  logic [20:0]   w_bx;
  logic [PW-1:0] w_rows [NR];
  logic [PW-1:0] w_l1 [8];
  logic [PW-1:0] w_l2 [6];
  logic [PW-1:0] w_l3 [4];
  logic [PW-1:0] w_l4 [3];
  logic [PW-1:0] w_l5 [2];
  logic [PW-1:0] w_prod;
  logic [PW-1:0] r_prod_p1;

  assign w_a_ext = {{2{SGN & A[17]}}, A};
  assign w_bx    = {{2{SGN & B[17]}}, B, 1'b0};

  always_comb begin
    logic [2:0]    dig;
    logic [MW-1:0] mult;
    logic [MW-1:0] x;
    logic          neg;
    logic [PW-1:0] cor;
    cor = SIGN_K;
    for (int r = 0; r < NR; r++) w_rows[r] = '0;
    for (int j = 0; j < ND; j++) begin
      dig = w_bx[2*j+2 -: 3];
      case (dig)
        3'b001, 3'b010: begin mult = w_a_ext;      neg = 1'b0; end
        3'b011:         begin mult = w_a_ext << 1; neg = 1'b0; end
        3'b100:         begin mult = w_a_ext << 1; neg = 1'b1; end
        3'b101, 3'b110: begin mult = w_a_ext;      neg = 1'b1; end
        default:        begin mult = '0;           neg = 1'b0; end
      endcase
      x = neg ? ~mult : mult;
      w_rows[j] = PW'({~x[MW-1], x[MW-2:0]}) << (2 * j);
      // Two's-complement +1 of a negated row lands at the row's LSB, below any SIGN_K bit.
      cor[2*j] = neg;
    end
    w_rows[10] = cor;
  end

  // Compression: 12 -> 8 -> 6 -> 4 -> 3 -> 2 rows.
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      w_l1[2*g]   = csa_s(w_rows[3*g], w_rows[3*g+1], w_rows[3*g+2]);
      w_l1[2*g+1] = csa_c(w_rows[3*g], w_rows[3*g+1], w_rows[3*g+2]);
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      w_l2[2*g]   = csa_s(w_l1[3*g], w_l1[3*g+1], w_l1[3*g+2]);
      w_l2[2*g+1] = csa_c(w_l1[3*g], w_l1[3*g+1], w_l1[3*g+2]);
    end
    w_l2[4] = w_l1[6];
    w_l2[5] = w_l1[7];
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      w_l3[2*g]   = csa_s(w_l2[3*g], w_l2[3*g+1], w_l2[3*g+2]);
      w_l3[2*g+1] = csa_c(w_l2[3*g], w_l2[3*g+1], w_l2[3*g+2]);
    end
  end

  always_comb begin
    w_l4[0] = csa_s(w_l3[0], w_l3[1], w_l3[2]);
    w_l4[1] = csa_c(w_l3[0], w_l3[1], w_l3[2]);
    w_l4[2] = w_l3[3];
    w_l5[0] = csa_s(w_l4[0], w_l4[1], w_l4[2]);
    w_l5[1] = csa_c(w_l4[0], w_l4[1], w_l4[2]);
  end

  assign w_prod = w_l5[0] + w_l5[1];

  // Stage p0 -> p1: product register
  always_ff @(posedge clk) begin
    if (rst) r_prod_p1 <= '0;
    else     r_prod_p1 <= w_prod;
  end

  assign P = r_prod_p1;

endmodule

// File: tb/tb_bmult_18x18.sv
// Bench for bmult_18x18: directed corner cases plus random pairs against an A*B model.
// Honors BMULT_SIGNED_EN the same way as the design.
module tb_bmult_18x18;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] A;
  logic [17:0] B;
  logic [35:0] P;

  int n_vec = 0;
  int n_err = 0;

  bmult_18x18 dut (.clk(clk), .rst(rst), .A(A), .B(B), .P(P));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: P=%09h expected %09h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] ref_prod(input logic [17:0] a, input logic [17:0] b);
    longint pa, pb, pr;
`ifdef BMULT_SIGNED_EN
    pa = longint'($signed(a));
    pb = longint'($signed(b));
`else
    pa = longint'({46'd0, a});
    pb = longint'({46'd0, b});
`endif
    pr = pa * pb;
    return pr[35:0];
  endfunction

  // Drive 1 ns after the falling edge, then sample 1 ns after the next rising edge.
  task automatic apply(input logic [17:0] a, input logic [17:0] b, input logic r);
    @(negedge clk);
    #1;
    A   = a;
    B   = b;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] ra, rb;
    logic [17:0] pa [3];
    logic [17:0] pb [3];
    logic [35:0] exp_max, exp_neg2;
    rst = 1'b1;
    A   = 18'h3FFFF;
    B   = 18'h3FFFF;

`ifdef BMULT_SIGNED_EN
    exp_max  = 36'h000000001;
    exp_neg2 = 36'hFFFFFFFFE;
`else
    exp_max  = 36'hFFFF80001;
    exp_neg2 = 36'h00007FFFE;
`endif

    apply(18'h3FFFF, 18'h3FFFF, 1'b1);
    check_eq("reset_c0", P, 36'h0);
    apply(18'h3FFFF, 18'h3FFFF, 1'b1);
    check_eq("reset_c1", P, 36'h0);
    apply(18'h3FFFF, 18'h3FFFF, 1'b0);
    check_eq("max_x_max", P, exp_max);

    apply(18'h20000, 18'h20000, 1'b0);
    check_eq("msb_x_msb", P, 36'h400000000);
    apply(18'h3FFFF, 18'h00002, 1'b0);
    check_eq("max_x_2", P, exp_neg2);

    apply(18'h00000, 18'h2B3C5, 1'b0);
    check_eq("a_zero", P, 36'h0);
    apply(18'h1F0E1, 18'h00000, 1'b0);
    check_eq("b_zero", P, 36'h0);

    pa[0] = 18'h00000; pb[0] = 18'h12345;
    pa[1] = 18'h00001; pb[1] = 18'h3FFFF;
    pa[2] = 18'h2AAAA; pb[2] = 18'h15555;
    for (int i = 0; i < 3; i++) begin
      apply(pa[i], pb[i], 1'b0);
      check_eq($sformatf("b2b_%0d", i), P, ref_prod(pa[i], pb[i]));
    end
`ifndef BMULT_SIGNED_EN
    check_eq("b2b_alt_lit", P, 36'd15270878322);
`endif

    // Mid-stream reset: a single zero cycle, then products resume.
    apply(18'h1234F, 18'h0ABCD, 1'b0);
    check_eq("pre_rst", P, ref_prod(18'h1234F, 18'h0ABCD));
    apply(18'h3FFFF, 18'h3FFFE, 1'b1);
    check_eq("mid_rst", P, 36'h0);
    apply(18'h3FFFF, 18'h3FFFE, 1'b0);
    check_eq("post_rst", P, ref_prod(18'h3FFFF, 18'h3FFFE));

    for (int i = 0; i < 20000; i++) begin
      ra = 18'($urandom);
      rb = 18'($urandom);
      if (i % 97 == 0) ra = (i % 2 == 0) ? 18'h20000 : 18'h1FFFF;
      if (i % 89 == 0) rb = 18'h3FFFF;
      apply(ra, rb, 1'b0);
      check_eq("random", P, ref_prod(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
